// File: rtl/ovp_link_pkg.sv
// rtl/ovp_link_pkg.sv - shared state type and link constants for the OVP aux link master
package ovp_link_pkg;

  localparam int LINK_BITS      = 32;
  localparam int ISTAT_CNT      = 8;
  localparam int STATUS_W       = 24;
  localparam int CREG_RES_BIT   = 31;
  localparam int CREG_BLOCK_BIT = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FRAME,
    ST_LOW,
    ST_HIGH,
    ST_LOAD,
    ST_END
  } link_state_e;

  // Main-register bit loaded during the low phase after falling edge n (n taken mod 32).
  function automatic logic [4:0] tx_bit_idx(input logic [4:0] pulse);
    return 5'(CREG_RES_BIT) - pulse;
  endfunction

endpackage

// File: rtl/ovp_sync2.sv
// rtl/ovp_sync2.sv - two-flop synchroniser for asynchronous link inputs
module ovp_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ovp_ax_link_master.sv
// rtl/ovp_ax_link_master.sv - aux-side master for the 4-wire OVP link
// Shifts control words into the main fault-latch block and reads back istat/status samples.
module ovp_ax_link_master
  import ovp_link_pkg::*;
#(
  parameter int HALF_DIV = 8,
  parameter int POLL_DIV = 1000000,
  parameter int PW       = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req,
  input  logic [31:0]          wr_data,
  input  logic                 rd_req,
  input  logic                 poll_en,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_valid,
  output logic [7:0]           rd_istat,
  output logic [23:0]          rd_status,
  output logic                 stat_ok,
  output logic                 stat_glitch,
  input  logic                 ax_res,
  output logic                 abort,
  output logic                 ax_clk,
  output logic                 ax_frame,
  output logic                 ax_write,
  output logic                 ax_data_in,
  input  logic                 ax_data
);

  localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  link_state_e           state_q, state_d;
  logic [HW-1:0]         hp_q, hp_d;
  logic [5:0]            n_q, n_d;
  logic                  is_wr_q, is_wr_d;
  logic [LINK_BITS-1:0]  creg_q, creg_d;
  logic [LINK_BITS-1:0]  cap_q, cap_d;
  logic [PW-1:0]         poll_q, poll_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ISTAT_CNT-1:0]  rd_istat_q, rd_istat_d;
  logic [STATUS_W-1:0]   rd_status_q, rd_status_d;
  logic                  stat_ok_q, stat_ok_d;
  logic                  stat_glitch_q, stat_glitch_d;
  logic                  dat_s, res_s, hp_last, poll_wrap, start;

  ovp_sync2 u_sync_data (.clk(clk), .rst_n(rst_n), .d(ax_data), .q(dat_s));
  ovp_sync2 u_sync_res  (.clk(clk), .rst_n(rst_n), .d(ax_res),  .q(res_s));

  assign hp_last   = (hp_q == HW'(HALF_DIV - 1));
  assign poll_wrap = (poll_q == PW'(POLL_DIV - 1));

  always_comb begin
    state_d       = state_q;
    hp_d          = hp_q;
    n_d           = n_q;
    is_wr_d       = is_wr_q;
    creg_d        = creg_q;
    cap_d         = cap_q;
    rd_valid_d    = rd_valid_q;
    rd_istat_d    = rd_istat_q;
    rd_status_d   = rd_status_q;
    stat_ok_d     = stat_ok_q;
    stat_glitch_d = stat_glitch_q;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    start         = 1'b0;
    poll_d        = poll_wrap ? '0 : poll_q + 1'b1;
    if (state_q != ST_IDLE) hp_d = hp_last ? '0 : hp_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (!res_s) begin
          if (wr_req) begin
            start   = 1'b1;
            is_wr_d = 1'b1;
            creg_d  = wr_data;
          end else if (rd_req || (poll_en && poll_wrap)) begin
            start   = 1'b1;
            is_wr_d = 1'b0;
          end
        end
      end
      ST_SETUP: if (hp_last) state_d = ST_FRAME;
      ST_FRAME: begin
        if (hp_last) begin
          state_d = ST_LOW;
          n_d     = 6'd1;
          if (!is_wr_q) cap_d[0] = dat_s;
        end
      end
      ST_LOW: if (hp_last) state_d = ST_HIGH;
      ST_HIGH: begin
        if (hp_last) begin
          if (!is_wr_q && n_q < 6'd32) cap_d[n_q[4:0]] = dat_s;
          if (n_q == 6'd32) begin
            state_d = is_wr_q ? ST_LOAD : ST_END;
          end else begin
            state_d = ST_LOW;
            n_d     = n_q + 6'd1;
          end
        end
      end
      ST_LOAD: if (hp_last) state_d = ST_END;
      ST_END: begin
        if (hp_last && !res_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (!is_wr_q) begin
            rd_valid_d    = 1'b1;
            rd_istat_d    = cap_q[ISTAT_CNT-1:0];
            stat_ok_d     = (cap_q[ISTAT_CNT-1:0] == '1);
            stat_glitch_d = (cap_q[ISTAT_CNT-1:0] != '0) && (cap_q[ISTAT_CNT-1:0] != '1);
            // Count k lands in status bit 31-k, so the captured word is bit-reversed.
            for (int j = 0; j < STATUS_W; j++) rd_status_d[j] = cap_q[LINK_BITS-1-j];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d = ST_SETUP;
      hp_d    = '0;
      poll_d  = '0;
    end
    if (state_q != ST_IDLE && res_s) begin
      state_d = ST_IDLE;
      hp_d    = '0;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hp_q          <= '0;
      n_q           <= '0;
      is_wr_q       <= 1'b0;
      creg_q        <= '0;
      cap_q         <= '0;
      poll_q        <= '0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_istat_q    <= '0;
      rd_status_q   <= '0;
      stat_ok_q     <= 1'b0;
      stat_glitch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hp_q          <= hp_d;
      n_q           <= n_d;
      is_wr_q       <= is_wr_d;
      creg_q        <= creg_d;
      cap_q         <= cap_d;
      poll_q        <= poll_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
      rd_valid_q    <= rd_valid_d;
      rd_istat_q    <= rd_istat_d;
      rd_status_q   <= rd_status_d;
      stat_ok_q     <= stat_ok_d;
      stat_glitch_q <= stat_glitch_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign abort       = abort_q;
  assign rd_valid    = rd_valid_q;
  assign rd_istat    = rd_istat_q;
  assign rd_status   = rd_status_q;
  assign stat_ok     = stat_ok_q;
  assign stat_glitch = stat_glitch_q;
  assign ax_clk      = (state_q != ST_LOW);
  assign ax_frame    = (state_q inside {ST_FRAME, ST_LOW, ST_HIGH, ST_LOAD});
  assign ax_write    = is_wr_q && (state_q inside {ST_SETUP, ST_FRAME, ST_LOW, ST_HIGH});

  // High phase already presents the bit for the next pulse.
  always_comb begin
    ax_data_in = 1'b0;
    if (is_wr_q) begin
      unique case (state_q)
        ST_FRAME: ax_data_in = creg_q[CREG_BLOCK_BIT];
        ST_LOW:   ax_data_in = creg_q[tx_bit_idx(n_q[4:0])];
        ST_HIGH:  ax_data_in = creg_q[tx_bit_idx(n_q[4:0] + 5'd1)];
        default:  ax_data_in = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ovp_ax_link_master.sv
// tb/tb_ovp_ax_link_master.sv - self-checking bench for ovp_ax_link_master
module tb_ovp_ax_link_master;

  localparam int HD   = 4;
  localparam int PD   = 50;
  localparam int L_WR = 68 * HD;
  localparam int L_RD = 67 * HD;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0, poll_en = 1'b0, ax_res = 1'b0, ax_data = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy, done, rd_valid, stat_ok, stat_glitch, abort;
  logic [7:0]  rd_istat;
  logic [23:0] rd_status;
  logic        ax_clk, ax_frame, ax_write, ax_data_in;

  ovp_ax_link_master #(.HALF_DIV(HD), .POLL_DIV(PD), .PW(6)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .poll_en(poll_en), .busy(busy), .done(done), .rd_valid(rd_valid), .rd_istat(rd_istat),
    .rd_status(rd_status), .stat_ok(stat_ok), .stat_glitch(stat_glitch), .ax_res(ax_res),
    .abort(abort), .ax_clk(ax_clk), .ax_frame(ax_frame), .ax_write(ax_write),
    .ax_data_in(ax_data_in), .ax_data(ax_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // Main fault-latch block model: counts falling edges inside a frame.
  int          k_m = 0;
  logic [31:0] creg_m = '0;
  logic [23:0] cmask_m = '0;
  logic [7:0]  istat_src = '0;
  logic [23:0] rstat_src = '0;

  function automatic logic src_bit(input int k);
    if (k < 8) return istat_src[k];
    return rstat_src[31 - k];
  endfunction

  always @(posedge ax_frame) begin
    k_m = 0;
    ax_data = src_bit(0);
  end
  always @(negedge ax_clk) begin
    if (ax_frame === 1'b1 && rst_n) begin
      k_m++;
      if (ax_write) creg_m[(63 - k_m) % 32] = ax_data_in;
      else if (k_m < 32) ax_data = src_bit(k_m);
    end
  end
  always @(negedge ax_write) if (ax_frame === 1'b1) cmask_m = creg_m[23:0];

  logic [7:0]  exp_istat = '0;
  logic [23:0] exp_status = '0;
  logic        exp_ok = 1'b0, exp_glitch = 1'b0, exp_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_read();
    exp_istat  = istat_src;
    exp_status = rstat_src;
    exp_ok     = (istat_src == 8'hFF);
    exp_glitch = (istat_src != 8'h00) && (istat_src != 8'hFF);
    exp_valid  = 1'b1;
  endtask

  task automatic check_rd(input string tag);
    check({tag, "_istat"}, rd_istat, exp_istat);
    check({tag, "_status"}, rd_status, exp_status);
    check({tag, "_flags"}, {rd_valid, stat_ok, stat_glitch}, {exp_valid, exp_ok, exp_glitch});
  endtask

  // Entered at a negedge with requests already driven; counts per-cycle samples.
  task automatic observe(input int ncyc, input int rd_at, output int busy_n, output int done_n,
                         output int abort_n);
    busy_n = 0; done_n = 0; abort_n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      busy_n += int'(busy);
      done_n += int'(done);
      abort_n += int'(abort);
      wr_req = 1'b0;
      rd_req = (i == rd_at);
    end
    rd_req = 1'b0;
  endtask

  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] data, input int rd_at,
                         output int busy_n, output int done_n, output int abort_n);
    wr_req = wr; rd_req = rd; wr_data = data;
    observe(400, rd_at, busy_n, done_n, abort_n);
  endtask

  int          b, d, a, got, nst, r0, exp_start;
  logic        prev, op;
  logic [31:0] data;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctl", {ax_clk, ax_frame, ax_write, ax_data_in, busy, done, abort, rd_valid, stat_ok,
                      stat_glitch}, 10'b10_0000_0000);
    check("rst_istat", rd_istat, 0);
    check("rst_status", rd_status, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 1'b0, 32'h8000_0A0B, -1, b, d, a);
    check("wr_creg", creg_m, 32'h8000_0A0B);
    check("wr_cmask", cmask_m, 24'h000A0B);
    check("wr_busy", b, L_WR);
    check("wr_done", d, 1);
    check("wr_rdvalid", rd_valid, 0);

    istat_src = 8'hFF; rstat_src = 24'h0A0B0C;
    run_txn(1'b0, 1'b1, '0, -1, b, d, a);
    model_read();
    check_rd("rd_ok");
    check("rd_busy", b, L_RD);
    check("rd_done", d, 1);

    istat_src = 8'hF0; rstat_src = 24'hC3A55A;
    run_txn(1'b0, 1'b1, '0, -1, b, d, a);
    model_read();
    check_rd("rd_glitch");

    for (int it = 0; it < 6; it++) begin
      op = 1'($urandom_range(0, 1));
      data = $urandom;
      istat_src = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      rstat_src = 24'($urandom);
      run_txn(op, !op, data, -1, b, d, a);
      if (op) begin
        check($sformatf("rnd%0d_creg", it), creg_m, data);
        check($sformatf("rnd%0d_cmask", it), cmask_m, data[23:0]);
      end else begin
        model_read();
      end
      check_rd($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_busy", it), b, op ? L_WR : L_RD);
      check($sformatf("rnd%0d_done", it), d, 1);
    end

    data = $urandom;
    run_txn(1'b1, 1'b1, data, 100, b, d, a);
    check("arb_creg", creg_m, data);
    check("arb_busy", b, L_WR);
    check("arb_done", d, 1);
    check_rd("arb");

    istat_src = 8'hFF; rstat_src = 24'h123456;
    run_txn(1'b0, 1'b1, '0, -1, b, d, a);
    model_read();
    check_rd("pre_abort");
    istat_src = 8'h0F; rstat_src = 24'hABCDEF;
    rd_req = 1'b1;
    got = 0;
    for (int i = 0; i < 600 && got == 0; i++) begin
      @(negedge clk);
      rd_req = 1'b0;
      if (k_m == 15) got = 1;
    end
    check("abort_reach_p15", got, 1);
    ax_res = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_frame", ax_frame, 0);
    check("abort_pulse", abort, 1);
    check("abort_busy", busy, 0);
    observe(60, 10, b, d, a);
    check("abort_nodone", d, 0);
    check("abort_ignored_req", b, 0);
    check("abort_once", a, 0);
    check_rd("post_abort");
    ax_res = 1'b0;
    observe(10, -1, b, d, a);

    observe(200, -1, b, d, a);
    check("nopoll_busy", b, 0);

    wr_req = 1'b1; wr_data = $urandom;
    @(negedge clk);
    wr_req = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0; poll_en = 1'b1;
    @(negedge clk);
    check("midrst_idle", {busy, ax_frame, ax_write, ax_clk}, 4'b0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = cyc; prev = 1'b0; nst = 0; exp_start = PD;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (busy && !prev) begin
        if (nst < 3) check($sformatf("poll_start%0d", nst), cyc - r0, exp_start);
        exp_start += PD * ((L_RD + PD) / PD);
        nst++;
      end
      prev = busy;
    end
    check("poll_count", nst, 3);
    poll_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
